// File: rtl/or_rtl_pkg.sv
// ----------------------------------------------------------------------------
// or_rtl_pkg
// Shared constants and helpers for the or_rtl block.
//   CNT_W_DEFAULT : default width of the high-cycle counter
//   CNT_W_MAX     : widest counter the block supports
//   sat_value(w)  : all-ones value of a w-bit counter (its saturation point),
//                   returned in a CNT_W_MAX-bit container
// ----------------------------------------------------------------------------
package or_rtl_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int CNT_W_MIN     = 2;
  localparam int CNT_W_MAX     = 32;

  // Built bit by bit so that w == 32 needs no special case for an
  // overflowing shift.
  function automatic logic [CNT_W_MAX-1:0] sat_value(input int w);
    logic [CNT_W_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < CNT_W_MAX; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/or_sat_counter.sv
// ----------------------------------------------------------------------------
// or_sat_counter
// Saturating up-counter. Counts edges that sample inc==1 and stops at the
// all-ones value instead of wrapping.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (highest priority)
//   clr : synchronous active-high clear (beats inc on the same edge)
//   inc : count enable
//   cnt : current count, W bits
// ----------------------------------------------------------------------------
module or_sat_counter
  import or_rtl_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] SAT = W'(sat_value(W));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/or_rtl.sv
// ----------------------------------------------------------------------------
// or_rtl
// Two-input OR with registered observation logic around it.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset of all registered outputs
//   a, b     : OR operands
//   clr      : synchronous active-high clear of sticky and high_cnt only
//   o        : a | b, purely combinational (works with no clock/reset)
//   o_q      : o delayed by one clock
//   o_rise   : one-cycle pulse after an edge that saw o=1 while o_q=0
//   o_fall   : one-cycle pulse after an edge that saw o=0 while o_q=1
//   sticky   : set once o has been sampled high since the last rst/clr
//              (tied low when STICKY_EN == 0)
//   high_cnt : saturating count of edges that sampled o=1
// ----------------------------------------------------------------------------
module or_rtl
  import or_rtl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int STICKY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             o,
  output logic             o_q,
  output logic             o_rise,
  output logic             o_fall,
  output logic             sticky,
  output logic [CNT_W-1:0] high_cnt
);

  // The OR itself: no state, no gating, X/Z propagate naturally.
  assign o = a | b;

  // Edge detection compares the new sample against o_q before it updates,
  // so right after reset o_q=0 and a high o immediately yields o_rise.
  // clr deliberately has no effect here.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q    <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_q    <= o;
      o_rise <= o & ~o_q;
      o_fall <= ~o & o_q;
    end
  end

  generate
    if (STICKY_EN != 0) begin : g_sticky
      logic sticky_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sticky_q <= 1'b0;
        end else if (clr) begin
          sticky_q <= 1'b0;
        end else if (o) begin
          sticky_q <= 1'b1;
        end
      end

      assign sticky = sticky_q;
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

  or_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (o),
    .cnt (high_cnt)
  );

endmodule

// File: tb/tb_or_rtl.sv
// ----------------------------------------------------------------------------
// tb_or_rtl
// Directed plus short random stimulus for or_rtl. Three instances share the
// inputs: default (CNT_W=8), a narrow counter (CNT_W=2) and one without the
// sticky flag. A reference model computes the expected registered outputs at
// drive time; they are queued and compared after the following rising edge.
// ----------------------------------------------------------------------------
module tb_or_rtl;

  // --------------------------------------------------------------------------
  // clock / reset
  // --------------------------------------------------------------------------
  logic clk;
  logic clk_en;
  logic rst;
  logic a;
  logic b;
  logic clr;

  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
  end

  // Gated so the combinational checks can run with the clock idle.
  always #5 if (clk_en) clk = ~clk;

  // --------------------------------------------------------------------------
  // DUTs
  // --------------------------------------------------------------------------
  logic       o8, oq8, rise8, fall8, sticky8;
  logic [7:0] cnt8;
  logic       o2, oq2, rise2, fall2, sticky2;
  logic [1:0] cnt2;
  logic       on, oqn, risen, falln, stickyn;
  logic [7:0] cntn;

  or_rtl dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .o(o8), .o_q(oq8), .o_rise(rise8), .o_fall(fall8),
    .sticky(sticky8), .high_cnt(cnt8)
  );

  or_rtl #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .o(o2), .o_q(oq2), .o_rise(rise2), .o_fall(fall2),
    .sticky(sticky2), .high_cnt(cnt2)
  );

  or_rtl #(.STICKY_EN(0)) dut_ns (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .o(on), .o_q(oqn), .o_rise(risen), .o_fall(falln),
    .sticky(stickyn), .high_cnt(cntn)
  );

  // --------------------------------------------------------------------------
  // scoreboard
  // expected word: {o_q, o_rise, o_fall, sticky, cnt8[7:0], cnt2[1:0]}
  // --------------------------------------------------------------------------
  localparam int EXP_W = 14;
  logic [EXP_W-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic m_oq, m_rise, m_fall, m_sticky;
  int   m_cnt8, m_cnt2;

  initial begin
    m_oq = 0; m_rise = 0; m_fall = 0; m_sticky = 0;
    m_cnt8 = 0; m_cnt2 = 0;
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge with the given inputs and queue the result.
  task automatic model_edge(input logic ma, input logic mb,
                            input logic mclr, input logic mrst);
    logic mo;
    mo = ma | mb;
    if (mrst) begin
      m_oq = 0; m_rise = 0; m_fall = 0; m_sticky = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_rise = mo & ~m_oq;
      m_fall = ~mo & m_oq;
      m_oq   = mo;
      if (mclr) begin
        m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (mo) begin
        m_sticky = 1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    exp_q.push_back({m_oq, m_rise, m_fall, m_sticky,
                     8'(m_cnt8), 2'(m_cnt2)});
  endtask

  // --------------------------------------------------------------------------
  // driver: one clock cycle with the given inputs
  // --------------------------------------------------------------------------
  task automatic step(input logic na, input logic nb,
                      input logic nclr, input logic nrst);
    logic [EXP_W-1:0] e;
    @(negedge clk);
    a = na; b = nb; clr = nclr; rst = nrst;
    #1;
    check("o_comb", {7'd0, o8}, {7'd0, na | nb});
    model_edge(na, nb, nclr, nrst);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check("o_q",      {7'd0, oq8},     {7'd0, e[13]});
      check("o_rise",   {7'd0, rise8},   {7'd0, e[12]});
      check("o_fall",   {7'd0, fall8},   {7'd0, e[11]});
      check("sticky",   {7'd0, sticky8}, {7'd0, e[10]});
      check("high_cnt", cnt8,            e[9:2]);
      check("cnt_w2",   {6'd0, cnt2},    {6'd0, e[1:0]});
      check("sticky_off", {7'd0, stickyn}, 8'd0);
      check("cnt_ns",   cntn,            e[9:2]);
    end
  endtask

  // --------------------------------------------------------------------------
  // watchdog
  // --------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // directed sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [1:0] pats [4];
    logic       exp_o [4];
    pats  = '{2'b00, 2'b10, 2'b01, 2'b11};   // {a, b}
    exp_o = '{1'b0, 1'b1, 1'b1, 1'b1};

    a = 0; b = 0; clr = 0; rst = 0;

    // truth table with the clock idle
    for (int i = 0; i < 4; i++) begin
      a = pats[i][1];
      b = pats[i][0];
      #1;
      check("o_truth", {7'd0, o8}, {7'd0, exp_o[i]});
      #4;
    end

    clk_en = 1'b1;

    // reset held two cycles with a=b=1, then release
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);

    // o = 0,1,1,0 : rise after edge 2, fall after edge 4
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // saturation of the 2-bit counter over six high cycles
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // clr beats o=1 on the same edge, counting resumes after
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);

    // rst with clr mid-count, o keeps following a|b
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    step(0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
